// File: rtl/future_pkg.sv
`default_nettype none
// ============================================================================
// Module   : future_pkg
// Purpose  : Shared types and constants for the key/round-constant sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package future_pkg;

  localparam int ROUNDS_DEF = 10;
  localparam int SLICES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SLICE = 3'd2,
    ST_ROT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Lane-wide select patterns for the XOR datapath muxes
  localparam logic [15:0] SEL_K0   = 16'h0000;
  localparam logic [15:0] SEL_K1   = 16'hFFFF;
  localparam logic [15:0] SEL_RC   = 16'hFFFF;
  localparam logic [15:0] SEL_ZERO = 16'h0000;

  // Even rounds mix K0, odd rounds mix K1
  function automatic logic [15:0] key_sel(input logic [3:0] round);
    return round[0] ? SEL_K1 : SEL_K0;
  endfunction

endpackage : future_pkg
`default_nettype wire

// File: rtl/future_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : future_round_ctrl
// Purpose  : Sequences a 64-bit block through ROUNDS rounds of the 16-bit
//            key/round-constant XOR datapath, one slice per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module future_round_ctrl
  import future_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int SLICES = SLICES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        k_rst_o,
  output logic        k_en_o,
  output logic        k_sh16_o,
  output logic        k_sh5_o,
  output logic        rc_rst_o,
  output logic        rc_en_o,
  output logic        rc_sh16_o,
  output logic        rc_sh5_o,
  output logic [0:15] sel_k0k1_o,
  output logic [0:15] sel_rc01_o,
  output logic        y_vld_o,
  output logic [1:0]  y_slice_o,
  output logic [3:0]  y_round_o,
  output logic        y_last_o
);

  localparam logic [1:0] LAST_SLICE = 2'(SLICES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e      state_q;
  logic [1:0]  slice_q;
  logic [3:0]  round_q;
  logic        busy_q;
  logic        done_q;
  logic        load_q;     // LOAD cycle: load + enable both register groups
  logic        rot_q;      // ROT cycle: RC1 rotates by 5
  logic        rot_k_q;    // ROT cycle after an odd round: keys rotate by 5
  logic [15:0] sel_k0k1_q;
  logic [15:0] sel_rc01_q;
  logic        w_adv;

  // Controller state, slice/round counters and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slice_q    <= 2'd0;
      round_q    <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b0;
      rot_q      <= 1'b0;
      rot_k_q    <= 1'b0;
      sel_k0k1_q <= SEL_K0;
      sel_rc01_q <= SEL_ZERO;
    end else begin
      // Single-cycle strobes clear unless re-armed below
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      rot_q   <= 1'b0;
      rot_k_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_LOAD;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            slice_q <= 2'd0;
            round_q <= 4'd0;
          end
        end
        ST_LOAD: begin
          state_q    <= ST_SLICE;
          sel_k0k1_q <= key_sel(round_q);
          sel_rc01_q <= SEL_RC;
        end
        ST_SLICE: begin
          // A stalled slice holds everything, including the sel vectors
          if (ready_i) begin
            if (slice_q == LAST_SLICE) begin
              slice_q <= 2'd0;
              if (round_q < LAST_ROUND) begin
                state_q <= ST_ROT;
                rot_q   <= 1'b1;
                rot_k_q <= round_q[0];
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                round_q <= 4'd0;
              end
            end else begin
              slice_q <= slice_q + 2'd1;
            end
          end
        end
        ST_ROT: begin
          state_q    <= ST_SLICE;
          round_q    <= round_q + 4'd1;
          sel_k0k1_q <= key_sel(round_q + 4'd1);
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A slice only advances when downstream accepts it, so these follow ready
  assign w_adv = (state_q == ST_SLICE) && ready_i;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign k_rst_o    = load_q;
  assign rc_rst_o   = load_q;
  assign k_en_o     = load_q | rot_k_q | w_adv;
  assign rc_en_o    = load_q | rot_q | w_adv;
  assign k_sh16_o   = w_adv;
  assign rc_sh16_o  = w_adv;
  assign k_sh5_o    = rot_k_q;
  assign rc_sh5_o   = rot_q;
  assign sel_k0k1_o = sel_k0k1_q;
  assign sel_rc01_o = sel_rc01_q;
  assign y_vld_o    = w_adv;
  assign y_slice_o  = slice_q;
  assign y_round_o  = round_q;
  assign y_last_o   = w_adv && (slice_q == LAST_SLICE) && (round_q == LAST_ROUND);

endmodule : future_round_ctrl
`default_nettype wire

// File: tb/tb_future_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_future_round_ctrl
// Purpose  : Scoreboard bench for the round sequencer (ROUNDS=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_future_round_ctrl;

  localparam int ROUNDS = 10;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        ready_i;
  logic        busy_o, done_o;
  logic        k_rst_o, k_en_o, k_sh16_o, k_sh5_o;
  logic        rc_rst_o, rc_en_o, rc_sh16_o, rc_sh5_o;
  logic [0:15] sel_k0k1_o, sel_rc01_o;
  logic        y_vld_o;
  logic [1:0]  y_slice_o;
  logic [3:0]  y_round_o;
  logic        y_last_o;
  logic [49:0] all_out;

  typedef struct {
    logic [1:0]  sl;
    logic [3:0]  rd;
    logic [15:0] sel;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  future_round_ctrl #(.ROUNDS(ROUNDS), .SLICES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .k_rst_o    (k_rst_o),
    .k_en_o     (k_en_o),
    .k_sh16_o   (k_sh16_o),
    .k_sh5_o    (k_sh5_o),
    .rc_rst_o   (rc_rst_o),
    .rc_en_o    (rc_en_o),
    .rc_sh16_o  (rc_sh16_o),
    .rc_sh5_o   (rc_sh5_o),
    .sel_k0k1_o (sel_k0k1_o),
    .sel_rc01_o (sel_rc01_o),
    .y_vld_o    (y_vld_o),
    .y_slice_o  (y_slice_o),
    .y_round_o  (y_round_o),
    .y_last_o   (y_last_o)
  );

  assign all_out = {busy_o, done_o, k_rst_o, k_en_o, k_sh16_o, k_sh5_o,
                    rc_rst_o, rc_en_o, rc_sh16_o, rc_sh5_o, sel_k0k1_o,
                    sel_rc01_o, y_vld_o, y_slice_o, y_round_o, y_last_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected slice stream of one block
  task automatic push_block();
    for (int r = 0; r < ROUNDS; r++) begin
      for (int s = 0; s < 4; s++) begin
        exp_t e;
        e.sl   = 2'(s);
        e.rd   = 4'(r);
        e.sel  = (r % 2 == 1) ? 16'hFFFF : 16'h0000;
        e.last = (r == ROUNDS - 1) && (s == 3);
        sb.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_hold: outputs %h expected 0", all_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== '0) begin
        errors++; $display("FAIL idle_zero cyc %0d: outputs %h expected 0", i, all_out);
      end
    end
  endtask

  // One full block; cycle 1 is the cycle after the edge that samples start
  task automatic run_block(input bit do_stall, input int exp_done);
    int cyc = 0, done_cyc = -1, vld_cnt = 0, rot_cnt = 0, ksh5_cnt = 0;
    int krst_cnt = 0, last_cnt = 0, stall_cnt = 0;
    exp_t e;
    push_block();
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (do_stall && sb.size() > 0 && sb[0].rd == 4'd2 && sb[0].sl == 2'd1 && stall_cnt < 3) begin
        ready_i = 1'b0; stall_cnt++;
      end else begin
        ready_i = 1'b1;
      end
      #1;
      if (!ready_i) begin
        checks++;
        if ({k_en_o, rc_en_o, k_sh16_o, rc_sh16_o, k_sh5_o, rc_sh5_o, y_vld_o} !== 7'd0 ||
            y_slice_o !== 2'd1 || y_round_o !== 4'd2) begin
          errors++;
          $display("FAIL stall_hold cyc %0d: en %b%b vld %b slice %0d round %0d expected no strobes, slice 1 round 2",
                   cyc, k_en_o, rc_en_o, y_vld_o, y_slice_o, y_round_o);
        end
      end
      checks++;
      if ((k_sh16_o && k_sh5_o) || (rc_sh16_o && rc_sh5_o)) begin
        errors++; $display("FAIL sh16_sh5_overlap cyc %0d: both strobes high, expected exclusive", cyc);
      end
      checks++;
      if (busy_o !== !done_o) begin
        errors++; $display("FAIL busy cyc %0d: busy %b expected %b", cyc, busy_o, !done_o);
      end
      if (k_rst_o) begin
        krst_cnt++;
        checks++;
        if (cyc != 1 || rc_rst_o !== 1'b1 || k_en_o !== 1'b1 || rc_en_o !== 1'b1) begin
          errors++; $display("FAIL load cyc %0d: k_rst at cycle %0d rc_rst %b expected cycle 1 with rc_rst/en", cyc, cyc, rc_rst_o);
        end
      end
      if (rc_sh5_o) begin
        checks++;
        if (k_sh5_o !== rot_cnt[0] || rc_en_o !== 1'b1 || y_vld_o !== 1'b0 || k_en_o !== rot_cnt[0]) begin
          errors++; $display("FAIL rot %0d: k_sh5 %b k_en %b y_vld %b expected k_sh5 %b", rot_cnt, k_sh5_o, k_en_o, y_vld_o, rot_cnt[0]);
        end
        rot_cnt++;
      end
      if (k_sh5_o) ksh5_cnt++;
      if (y_vld_o) begin
        vld_cnt++;
        if (y_last_o) last_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL slice_extra cyc %0d: unexpected y_vld", cyc);
        end else begin
          e = sb.pop_front();
          if (y_slice_o !== e.sl || y_round_o !== e.rd || sel_k0k1_o !== e.sel ||
              sel_rc01_o !== 16'hFFFF || y_last_o !== e.last || k_sh16_o !== 1'b1 || rc_en_o !== 1'b1) begin
            errors++;
            $display("FAIL slice cyc %0d: got s%0d r%0d k %h rc %h last %b expected s%0d r%0d k %h rc ffff last %b",
                     cyc, y_slice_o, y_round_o, sel_k0k1_o, sel_rc01_o, y_last_o, e.sl, e.rd, e.sel, e.last);
          end
        end
      end
      if (done_o) done_cyc = cyc;
    end
    ready_i = 1'b1;
    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, exp_done);
    end
    checks++;
    if (vld_cnt != 40 || rot_cnt != 9 || ksh5_cnt != 4 || krst_cnt != 1 || last_cnt != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL counts: vld %0d rot %0d ksh5 %0d krst %0d last %0d left %0d expected 40 9 4 1 1 0",
               vld_cnt, rot_cnt, ksh5_cnt, krst_cnt, last_cnt, sb.size());
    end
    sb.delete();
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || y_vld_o !== 1'b0) begin
      errors++; $display("FAIL post_done: busy %b done %b vld %b expected 0 0 0", busy_o, done_o, y_vld_o);
    end
  endtask

  task automatic test_full_block();
    run_block(1'b0, 51);
  endtask

  task automatic test_stall();
    run_block(1'b1, 54);
  endtask

  task automatic test_abort();
    int cyc = 0;
    bit hit = 1'b0;
    exp_t e;
    push_block();
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    while (!hit && cyc < 200) begin
      @(negedge clk); cyc++;
      if (sb.size() > 0 && sb[0].rd == 4'd4 && sb[0].sl == 2'd2) begin
        hit = 1'b1;
        #1;
        checks++;
        if (y_vld_o !== 1'b1 || y_slice_o !== 2'd2 || y_round_o !== 4'd4) begin
          errors++; $display("FAIL abort_pos: vld %b s%0d r%0d expected 1 s2 r4", y_vld_o, y_slice_o, y_round_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
          errors++; $display("FAIL abort_async: outputs %h expected 0", all_out);
        end
      end else begin
        #1;
        if (y_vld_o && sb.size() > 0) e = sb.pop_front();
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL abort_timeout: round 4 slice 2 not reached");
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== '0) begin
        errors++; $display("FAIL abort_idle cyc %0d: outputs %h expected 0", i, all_out);
      end
    end
    run_block(1'b0, 51);
  endtask

  task automatic test_back_to_back();
    int cyc = 0, dones = 0, krst_cnt = 0, vld_cnt = 0;
    int done_c[2];
    int krst_c[2];
    exp_t e;
    push_block(); push_block();
    ready_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    while (dones < 2 && cyc < 300) begin
      @(negedge clk); cyc++; #1;
      if (k_rst_o) begin
        if (krst_cnt < 2) krst_c[krst_cnt] = cyc;
        krst_cnt++;
      end
      if (y_vld_o) begin
        vld_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_extra cyc %0d: unexpected y_vld", cyc);
        end else begin
          e = sb.pop_front();
          if (y_slice_o !== e.sl || y_round_o !== e.rd || sel_k0k1_o !== e.sel || y_last_o !== e.last) begin
            errors++;
            $display("FAIL b2b_slice cyc %0d: got s%0d r%0d k %h last %b expected s%0d r%0d k %h last %b",
                     cyc, y_slice_o, y_round_o, sel_k0k1_o, y_last_o, e.sl, e.rd, e.sel, e.last);
          end
        end
      end
      if (cyc == 52) begin
        checks++;
        if (busy_o !== 1'b0 || k_rst_o !== 1'b0) begin
          errors++; $display("FAIL b2b_idle_gap: busy %b k_rst %b expected 0 0", busy_o, k_rst_o);
        end
      end
      if (done_o) begin
        done_c[dones] = cyc;
        dones++;
        if (dones == 2) start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    checks++;
    if (dones != 2 || done_c[0] != 51 || done_c[1] != 103) begin
      errors++; $display("FAIL b2b_done: count %0d at %0d/%0d expected 2 at 51/103", dones, done_c[0], done_c[1]);
    end
    checks++;
    if (krst_cnt != 2 || krst_c[0] != 1 || krst_c[1] != 53 || vld_cnt != 80 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_load: k_rst %0d at %0d/%0d vld %0d expected 2 at 1/53 vld 80",
               krst_cnt, krst_c[0], krst_c[1], vld_cnt);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || k_rst_o !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: busy %b k_rst %b expected idle", busy_o, k_rst_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_future_round_ctrl
`default_nettype wire
